// File: rtl/pingpong_dbuf.sv
// rtl/pingpong_dbuf.sv - two-bank ping-pong buffer with commit/release ownership handshake
// Optional output register stage on the read port: define PINGPONG_DBUF_OUT_PIPE_EN.
module pingpong_dbuf #(
    parameter int DWIDTH    = 40,
    parameter int AWIDTH    = 11,
    parameter int NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_commit,
    input  logic [AWIDTH:0]   wr_len,
    output logic              wr_ready,
    output logic              wr_overflow,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic [AWIDTH:0]   rd_len,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [AWIDTH:0] NW = (AWIDTH+1)'(NUM_WORDS);

    logic [DWIDTH-1:0] mem0 [NUM_WORDS];
    logic [DWIDTH-1:0] mem1 [NUM_WORDS];

    logic            wbank;
    logic            rbank;
    logic [1:0]      bank_full;
    logic [AWIDTH:0] len0;
    logic [AWIDTH:0] len1;
    logic            overflow_q;

    logic            wr_in_range;
    logic            rd_in_range;
    logic            do_write;
    logic            do_commit;
    logic            do_release;
    logic            do_read;
    logic [AWIDTH:0] commit_len;

    assign wr_ready    = ~bank_full[wbank];
    assign rd_avail    = bank_full[rbank];
    assign rd_len      = rd_avail ? (rbank ? len1 : len0) : '0;
    assign wr_overflow = overflow_q;

    assign wr_in_range = {1'b0, wr_addr} < NW;
    assign rd_in_range = {1'b0, rd_addr} < NW;
    assign do_write    = wr_en && wr_ready && wr_in_range;
    assign do_commit   = wr_commit && wr_ready;
    assign do_release  = rd_release && rd_avail;
    assign do_read     = rd_en && rd_avail;
    assign commit_len  = (wr_len > NW) ? NW : wr_len;

    // Storage is not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            if (wbank)
                mem1[wr_addr] <= wr_data;
            else
                mem0[wr_addr] <= wr_data;
        end
    end

    // Commit and release can never target the same bank, so their updates to
    // bank_full are independent bit writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            bank_full  <= 2'b00;
            len0       <= '0;
            len1       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_commit) begin
                bank_full[wbank] <= 1'b1;
                if (wbank)
                    len1 <= commit_len;
                else
                    len0 <= commit_len;
                wbank <= ~wbank;
            end
            if (do_release) begin
                bank_full[rbank] <= 1'b0;
                rbank            <= ~rbank;
            end
            if ((wr_en || wr_commit) && !wr_ready)
                overflow_q <= 1'b1;
        end
    end

    logic              rd_valid_q;
    logic [DWIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (do_read) begin
            rd_valid_q <= 1'b1;
            if (!rd_in_range)
                rd_data_q <= '0;
            else if (rbank)
                rd_data_q <= mem1[rd_addr];
            else
                rd_data_q <= mem0[rd_addr];
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

`ifdef PINGPONG_DBUF_OUT_PIPE_EN
    logic              rd_valid_p;
    logic [DWIDTH-1:0] rd_data_p;

    // Stage one already holds its data between reads, so a plain copy keeps
    // rd_data stable while rd_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_p <= 1'b0;
            rd_data_p  <= '0;
        end else begin
            rd_valid_p <= rd_valid_q;
            rd_data_p  <= rd_data_q;
        end
    end

    assign rd_valid = rd_valid_p;
    assign rd_data  = rd_data_p;
`else
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_pingpong_dbuf.sv
// tb/tb_pingpong_dbuf.sv - scoreboard bench for pingpong_dbuf
module tb_pingpong_dbuf;

    localparam int DW = 40;
    localparam int AW = 11;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_commit;
    logic [AW:0]   wr_len;
    logic          wr_ready;
    logic          wr_overflow;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_release;
    logic          rd_avail;
    logic [AW:0]   rd_len;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    pingpong_dbuf #(.DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_len(wr_len),
        .wr_ready(wr_ready), .wr_overflow(wr_overflow),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_avail(rd_avail), .rd_len(rd_len),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data %0h expected no read", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit(input logic [AW:0] len);
        wr_commit = 1'b1; wr_len = len;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_en = 1'b1; rd_addr = a;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
        wr_len = '0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        chk("reset_wr_ready", 64'(wr_ready), 64'd1);
        chk("reset_rd_avail", 64'(rd_avail), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_overflow", 64'(wr_overflow), 64'd0);
        chk("reset_rd_len", 64'(rd_len), 64'd0);

        // Bank 0: four words, commit length 4
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(40'hA0 + i));
        chk("pre_commit_rd_avail", 64'(rd_avail), 64'd0);
        commit(12'd4);
        chk("commit_rd_avail", 64'(rd_avail), 64'd1);
        chk("commit_rd_len", 64'(rd_len), 64'd4);
        chk("commit_wr_ready", 64'(wr_ready), 64'd1);
        rd(11'd2, 40'hA2);
        rd(11'd0, 40'hA0);

        // Bank 1: three words, commit length 5 -> both banks full
        wr(11'd0, 40'hB0);
        wr(11'd1, 40'hB1);
        wr(11'd2, 40'hB2);
        commit(12'd5);
        chk("both_full_wr_ready", 64'(wr_ready), 64'd0);
        chk("both_full_overflow", 64'(wr_overflow), 64'd0);
        wr(11'd1, 40'hFF);
        chk("overflow_set", 64'(wr_overflow), 64'd1);
        rd(11'd1, 40'hA1);
        rd(11'd3, 40'hA3);

        // Release bank 0 while the producer is stalled
        release_bank();
        chk("release_wr_ready", 64'(wr_ready), 64'd1);
        chk("release_rd_avail", 64'(rd_avail), 64'd1);
        chk("release_rd_len", 64'(rd_len), 64'd5);
        chk("overflow_sticky", 64'(wr_overflow), 64'd1);
        rd(11'd1, 40'hB1);

        // Same-cycle write+commit into bank 0 and read+release of bank 1
        wr_en = 1'b1; wr_addr = 11'd7; wr_data = 40'h55; wr_commit = 1'b1; wr_len = 12'd8;
        rd_en = 1'b1; rd_addr = 11'd2; rd_release = 1'b1;
        exp_q.push_back(40'hB2);
        tick();
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        chk("swap_wr_ready", 64'(wr_ready), 64'd1);
        chk("swap_rd_avail", 64'(rd_avail), 64'd1);
        chk("swap_rd_len", 64'(rd_len), 64'd8);
        rd(11'd7, 40'h55);

        // Oversized commit on bank 1 saturates to NUM_WORDS
        wr(11'd0, 40'hC0);
        commit(12'd3000);
        chk("sat_wr_ready", 64'(wr_ready), 64'd0);
        release_bank();
        chk("sat_rd_avail", 64'(rd_avail), 64'd1);
        chk("sat_rd_len", 64'(rd_len), 64'd2048);
        chk("sat_wr_ready_after_rel", 64'(wr_ready), 64'd1);

        // Streaming reads interrupted by reset
        rd_en = 1'b1; rd_addr = 11'd0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(40'hC0);
            tick();
        end
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_reset_rd_data", 64'(rd_data), 64'd0);
        chk("mid_reset_wr_ready", 64'(wr_ready), 64'd1);
        chk("mid_reset_rd_avail", 64'(rd_avail), 64'd0);
        chk("mid_reset_rd_len", 64'(rd_len), 64'd0);
        chk("mid_reset_overflow", 64'(wr_overflow), 64'd0);
        rd_en = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_reset_rd_valid", 64'(rd_valid), 64'd0);
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pingpong_dbuf.md
# pingpong_dbuf

Parametrised two-bank ping-pong buffer with ownership handshake: a producer fills one bank while a consumer drains the other, and the banks swap on explicit commit/release events rather than a free-running toggle. Each bank carries a full flag and a committed length, so back-pressure, overflow and partial frames are handled in hardware. The block sits between a streaming producer (e.g. DMA/layer output) and a compute consumer in the accelerator datapath.

## Interface
- DWIDTH, 40, data word width
- AWIDTH, 11, address width per bank
- NUM_WORDS, 2048, words per bank (≤ 2^AWIDTH)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe into producer bank
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- wr_commit  in  1  producer finished current bank
- wr_len  in  AWIDTH+1  valid word count latched at commit
- wr_ready  out  1  producer bank is free (not full)
- wr_overflow  out  1  sticky: write/commit attempted while wr_ready=0
- rd_en  in  1  read strobe from consumer bank
- rd_addr  in  AWIDTH  read address
- rd_release  in  1  consumer finished current bank
- rd_avail  out  1  consumer bank holds committed data
- rd_len  out  AWIDTH+1  committed length of consumer bank (0 when !rd_avail)
- rd_data  out  DWIDTH  read data
- rd_valid  out  1  rd_data valid this cycle

## Operation
- State: wbank, rbank (1 bit each), bank_full[1:0], len0/len1, overflow flag; memory is two inferred NUM_WORDS×DWIDTH arrays (contents not reset).
- wr_ready = ~bank_full[wbank]; rd_avail = bank_full[rbank]; both decoded from registers only.
- Write: wr_en && wr_ready && wr_addr < NUM_WORDS → mem[wbank][wr_addr] <= wr_data. wr_addr ≥ NUM_WORDS: dropped silently, no flag.
- Commit: wr_commit && wr_ready → bank_full[wbank] <= 1, len[wbank] <= min(wr_len, NUM_WORDS), wbank toggles.
- Release: rd_release && rd_avail → bank_full[rbank] <= 0, rbank toggles.
- Read: rd_en && rd_avail → rd_data <= mem[rbank][rd_addr], rd_valid <= 1; otherwise rd_valid <= 0, rd_data holds. rd_addr ≥ NUM_WORDS → rd_data <= 0, rd_valid <= 1.
- Overflow: wr_en or wr_commit while wr_ready=0 → wr_overflow <= 1 (cleared only by reset); the write/commit is discarded.
- Simultaneous events: wr_en with wr_commit writes into the bank being committed (pre-toggle). rd_en with rd_release reads the bank being released (pre-toggle). Commit and release in one cycle are independent (they cannot target the same bank: one requires full, the other empty).
- Reset values: wbank=0, rbank=0, bank_full=00, len0=len1=0, wr_overflow=0, rd_valid=0, rd_data=0, hence wr_ready=1, rd_avail=0, rd_len=0.
- Reset mid-operation discards both banks' ownership; a read issued the cycle before reset produces no rd_valid after reset.

## Timing
- Write: data visible to a read issued any cycle after the commit edge.
- Commit at edge N → rd_avail=1 from N+1 (if consumer was waiting on that bank); wr_ready reflects next bank at N+1.
- Release at edge N → wr_ready=1 at N+1 if producer was stalled on that bank.
- Read latency 1 cycle (rd_en at N → rd_valid/rd_data after edge N+1); latency 2 with output pipe (see Configuration).
- Full throughput: one write and one read per cycle sustained; zero-bubble swap when the other bank is already in the needed state.

## Configuration
- PINGPONG_DBUF_OUT_PIPE_EN defined: extra output register stage on rd_data/rd_valid; read latency 2; reset clears both stages.
- Undefined: single registered output, latency 1.

## Test plan
- Reset → wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, wr_overflow=0.
- Write addr 0..3 = 0xA0..0xA3, commit wr_len=4 → next cycle rd_avail=1, rd_len=4; read addr 2 → rd_data=0xA2 one cycle later (two with PINGPONG_DBUF_OUT_PIPE_EN).
- Fill bank0 and bank1 (commit both) without release → wr_ready=0; further wr_en → wr_overflow=1, bank contents unchanged on later readback.
- Release bank0 while producer stalled → wr_ready=1 next cycle; consumer now sees bank1, rd_len = bank1's committed length.
- Same-cycle wr_en(addr 7, 0x55)+wr_commit and rd_en+rd_release → 0x55 lands in committed bank; read returns data of released bank; wbank/rbank both toggle.
- wr_len=3000 commit → rd_len=2048; assert reset during streaming read → rd_valid=0 next cycle, all flags at reset values.
